// File: rtl/axis_fifo.sv
// axis_fifo: single-clock first-word-fall-through AXI4-Stream FIFO carrying data with TLAST
module axis_fifo #(
  parameter int DW = 8,
  parameter int DD = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready
);
  localparam int AW = $clog2(DD);
  localparam logic [AW:0] FULL = (AW+1)'(DD);
  logic [DW:0]   mem [DD];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          rst_q, wr, rd;
  always_comb begin
    s_tready = !rst_q && count != FULL;
    m_tvalid = count != '0;
    wr = s_tvalid && s_tready;
    rd = m_tvalid && m_tready;
    // Gate the head word so outputs read as zero while empty.
    {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {s_tlast, s_tdata};
endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed checks of reset, streaming, fill/drain, full-edge, TLAST and mid-stream reset
module tb_axis_fifo;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] s_tdata = 0;
  logic       s_tvalid = 0;
  logic       s_tlast = 0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready = 0;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] eq[$];
  logic [7:0] sb[4099];

  axis_fifo #(.DW(8), .DD(2048)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    s_tvalid = 0;
    m_tready = 1;
    while (eq.size() > 0) begin
      chk({tag, "_v"}, 32'(m_tvalid), 1);
      chk({tag, "_d"}, 32'({m_tlast, m_tdata}), 32'(eq.pop_front()));
      step();
    end
    chk({tag, "_empty"}, 32'(m_tvalid), 0);
    m_tready = 0;
  endtask

  task automatic fill(input string tag, input int n);
    m_tready = 0;
    s_tvalid = 1;
    for (int i = 0; i < n; i++) begin
      s_tdata = 8'(i);
      chk({tag, "_rdy"}, 32'(s_tready), 32'(i < 2048));
      if (i < 2048) eq.push_back({1'b0, 8'(i)});
      step();
    end
    s_tvalid = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_mvalid", 32'(m_tvalid), 0);
      chk("rst_sready", 32'(s_tready), 0);
    end
    rst = 0;
    step();
    chk("rel_sready", 32'(s_tready), 1);
    chk("rel_mvalid", 32'(m_tvalid), 0);
    chk("rel_mdata", 32'({m_tlast, m_tdata}), 0);

    // Streaming: one-cycle latency, ready never drops
    m_tready = 1;
    s_tvalid = 1;
    for (int i = 0; i <= 4099; i++) begin
      if (i > 0) begin
        chk("stream_v", 32'(m_tvalid), 1);
        chk("stream_d", 32'(m_tdata), 32'(sb[i-1]));
      end
      chk("stream_rdy", 32'(s_tready), 1);
      if (i < 4099) begin
        sb[i] = 8'($urandom);
        s_tdata = sb[i];
      end else s_tvalid = 0;
      step();
    end
    chk("stream_empty", 32'(m_tvalid), 0);

    // Fill past depth, then drain in order
    fill("fill", 2050);
    chk("full_rdy", 32'(s_tready), 0);
    chk("full_v", 32'(m_tvalid), 1);
    drain("fill_out");

    // At full, read and write together
    fill("refill", 2048);
    m_tready = 1;
    s_tvalid = 1;
    for (int j = 0; j < 100; j++) begin
      s_tdata = 8'(j + 8'h40);
      chk("sim_rdy", 32'(s_tready), 32'(j != 0));
      chk("sim_d", 32'({m_tlast, m_tdata}), 32'(eq.pop_front()));
      if (j != 0) eq.push_back({1'b0, 8'(j + 8'h40)});
      step();
    end
    drain("sim_out");

    // TLAST only on the fourth word
    s_tvalid = 1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 8'(8'h11 * (i + 1));
      s_tlast = (i == 3);
      eq.push_back({s_tlast, s_tdata});
      step();
    end
    s_tlast = 0;
    drain("tlast");

    // Mid-stream reset discards contents
    s_tvalid = 1;
    for (int i = 0; i < 10; i++) begin
      s_tdata = 8'(8'h80 + i);
      step();
    end
    s_tvalid = 0;
    rst = 1;
    step();
    chk("mrst_mvalid", 32'(m_tvalid), 0);
    chk("mrst_sready", 32'(s_tready), 0);
    chk("mrst_mdata", 32'({m_tlast, m_tdata}), 0);
    rst = 0;
    step();
    chk("mrel_sready", 32'(s_tready), 1);
    chk("mrel_mvalid", 32'(m_tvalid), 0);
    s_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      s_tdata = 8'(8'hC1 + i);
      eq.push_back({1'b0, s_tdata});
      step();
    end
    drain("mrst_out");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
